// File: rtl/csel_pipe_addsub_if.sv
// Handshake bundle for csel_pipe_addsub: operand side (in_*) and result side (out_*).
interface csel_pipe_addsub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf, zero
    );
endinterface

// File: rtl/csel_pipe_addsub.sv
// Pipelined carry-select adder/subtractor: one candidate stage, one selection stage
// per BLOCK-bit block, then a registered result stage; a single global advance stalls all.
module csel_pipe_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input logic               clk,
    input logic               rst,
    csel_pipe_addsub_if.slave bus
);
    localparam int unsigned NBLK = WIDTH / BLOCK;

    logic             adv;
    logic [WIDTH-1:0] beff;
    logic             cin_eff;
    logic [WIDTH-1:0] cand_s0;
    logic [WIDTH-1:0] cand_s1;
    logic [NBLK-1:0]  cand_co0;
    logic [NBLK-1:0]  cand_co1;
    logic             cand_m0;
    logic             cand_m1;

    // Stage p holds blocks 0..p-1 resolved in res_q[p]; cr_q[p] is the carry into block p.
    logic [NBLK:0]    vld_q;
    logic [WIDTH-1:0] s0_q  [NBLK];
    logic [WIDTH-1:0] s1_q  [NBLK];
    logic [NBLK-1:0]  co0_q [NBLK];
    logic [NBLK-1:0]  co1_q [NBLK];
    logic             m0_q  [NBLK];
    logic             m1_q  [NBLK];
    logic             cr_q  [NBLK+1];
    logic [WIDTH-1:0] res_q [NBLK+1];
    logic             msb_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;
    logic             zero_q;

    assign adv           = ~out_valid_q | bus.out_ready;
    assign bus.in_ready  = adv & ~rst;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

    always_comb begin
        beff     = bus.sub ? ~bus.b : bus.b;
        cin_eff  = bus.sub ? ~bus.c_in : bus.c_in;
        cand_s0  = '0;
        cand_s1  = '0;
        cand_co0 = '0;
        cand_co1 = '0;
        for (int unsigned k = 0; k < NBLK; k++) begin
            {cand_co0[k], cand_s0[k*BLOCK +: BLOCK]} =
                {1'b0, bus.a[k*BLOCK +: BLOCK]} + {1'b0, beff[k*BLOCK +: BLOCK]};
            {cand_co1[k], cand_s1[k*BLOCK +: BLOCK]} =
                {1'b0, bus.a[k*BLOCK +: BLOCK]} + {1'b0, beff[k*BLOCK +: BLOCK]} + (BLOCK+1)'(1);
        end
        // Carry into the MSB recovered from the top bit itself: c = a ^ b ^ s.
        cand_m0 = bus.a[WIDTH-1] ^ beff[WIDTH-1] ^ cand_s0[WIDTH-1];
        cand_m1 = bus.a[WIDTH-1] ^ beff[WIDTH-1] ^ cand_s1[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (adv) begin
            vld_q       <= {vld_q[NBLK-1:0], bus.in_valid};
            out_valid_q <= vld_q[NBLK];
            if (vld_q[NBLK]) begin
                sum_q   <= res_q[NBLK];
                c_out_q <= cr_q[NBLK];
                ovf_q   <= msb_q ^ cr_q[NBLK];
                zero_q  <= ~|res_q[NBLK];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s0_q[0]  <= cand_s0;
            s1_q[0]  <= cand_s1;
            co0_q[0] <= cand_co0;
            co1_q[0] <= cand_co1;
            m0_q[0]  <= cand_m0;
            m1_q[0]  <= cand_m1;
            cr_q[0]  <= cin_eff;
            res_q[0] <= '0;
            for (int unsigned p = 1; p < NBLK; p++) begin
                s0_q[p]  <= s0_q[p-1];
                s1_q[p]  <= s1_q[p-1];
                co0_q[p] <= co0_q[p-1];
                co1_q[p] <= co1_q[p-1];
                m0_q[p]  <= m0_q[p-1];
                m1_q[p]  <= m1_q[p-1];
            end
            for (int unsigned p = 1; p <= NBLK; p++) begin
                res_q[p] <= res_q[p-1];
                res_q[p][(p-1)*BLOCK +: BLOCK] <= cr_q[p-1] ? s1_q[p-1][(p-1)*BLOCK +: BLOCK]
                                                            : s0_q[p-1][(p-1)*BLOCK +: BLOCK];
                cr_q[p] <= cr_q[p-1] ? co1_q[p-1][p-1] : co0_q[p-1][p-1];
            end
            msb_q <= cr_q[NBLK-1] ? m1_q[NBLK-1] : m0_q[NBLK-1];
        end
    end
endmodule

// File: tb/tb_csel_pipe_addsub.sv
// Bench for csel_pipe_addsub: four widths driven in lockstep, checked against an
// arithmetic reference model with per-instance expected-result queues.
module tb_csel_pipe_addsub;
    localparam int NDUT = 4;

    typedef struct {
        logic [63:0] res;
        int unsigned acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_v;
    logic        in_valid_v;
    logic        out_ready_v;
    logic        cin_v;
    logic        sub_v;
    logic [63:0] a_v;
    logic [63:0] b_v;
    int unsigned cyc = 0;

    logic        o_vld [NDUT];
    logic        o_rdy [NDUT];
    logic [63:0] o_res [NDUT];

    exp_t        expq     [NDUT][$];
    logic [63:0] held_res [NDUT];
    logic        stalled  [NDUT];
    logic        lat_chk;
    logic        dir_en;
    logic [63:0] dir_res;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csel_pipe_addsub_if #(.WIDTH(16)) if16 ();
    csel_pipe_addsub_if #(.WIDTH(8))  if8  ();
    csel_pipe_addsub_if #(.WIDTH(32)) if32 ();
    csel_pipe_addsub_if #(.WIDTH(4))  if4  ();

    csel_pipe_addsub #(.WIDTH(16), .BLOCK(4)) dut16 (.clk(clk), .rst(rst_v), .bus(if16));
    csel_pipe_addsub #(.WIDTH(8),  .BLOCK(2)) dut8  (.clk(clk), .rst(rst_v), .bus(if8));
    csel_pipe_addsub #(.WIDTH(32), .BLOCK(8)) dut32 (.clk(clk), .rst(rst_v), .bus(if32));
    csel_pipe_addsub #(.WIDTH(4),  .BLOCK(4)) dut4  (.clk(clk), .rst(rst_v), .bus(if4));

    assign if16.in_valid = in_valid_v;  assign if16.out_ready = out_ready_v;
    assign if16.a = a_v[15:0];          assign if16.b = b_v[15:0];
    assign if16.c_in = cin_v;           assign if16.sub = sub_v;
    assign if8.in_valid = in_valid_v;   assign if8.out_ready = out_ready_v;
    assign if8.a = a_v[7:0];            assign if8.b = b_v[7:0];
    assign if8.c_in = cin_v;            assign if8.sub = sub_v;
    assign if32.in_valid = in_valid_v;  assign if32.out_ready = out_ready_v;
    assign if32.a = a_v[31:0];          assign if32.b = b_v[31:0];
    assign if32.c_in = cin_v;           assign if32.sub = sub_v;
    assign if4.in_valid = in_valid_v;   assign if4.out_ready = out_ready_v;
    assign if4.a = a_v[3:0];            assign if4.b = b_v[3:0];
    assign if4.c_in = cin_v;            assign if4.sub = sub_v;

    assign o_vld[0] = if16.out_valid;  assign o_rdy[0] = if16.in_ready;
    assign o_vld[1] = if8.out_valid;   assign o_rdy[1] = if8.in_ready;
    assign o_vld[2] = if32.out_valid;  assign o_rdy[2] = if32.in_ready;
    assign o_vld[3] = if4.out_valid;   assign o_rdy[3] = if4.in_ready;
    assign o_res[0] = {29'd0, if16.c_out, if16.ovf, if16.zero, 16'd0, if16.sum};
    assign o_res[1] = {29'd0, if8.c_out,  if8.ovf,  if8.zero,  24'd0, if8.sum};
    assign o_res[2] = {29'd0, if32.c_out, if32.ovf, if32.zero, if32.sum};
    assign o_res[3] = {29'd0, if4.c_out,  if4.ovf,  if4.zero,  28'd0, if4.sum};

    function automatic int unsigned wid(int d);
        case (d)
            0:       return 16;
            1:       return 8;
            2:       return 32;
            default: return 4;
        endcase
    endfunction

    function automatic int unsigned nb(int d);
        return (d == 3) ? 1 : 4;
    endfunction

    // Reference: exact integer arithmetic, then wrap and range-check for the flags.
    function automatic logic [63:0] model(int unsigned w, logic [63:0] a, logic [63:0] b,
                                          logic cin, logic sub);
        longint mask = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua   = longint'(a) & mask;
        longint ub   = longint'(b) & mask;
        longint sa   = (ua >= half) ? ua - (mask + 1) : ua;
        longint sb   = (ub >= half) ? ub - (mask + 1) : ub;
        longint ci   = cin ? 1 : 0;
        longint full;
        longint sres;
        longint s;
        logic   co;
        logic   ov;
        if (!sub) begin
            full = ua + ub + ci;
            co   = full > mask;
            sres = sa + sb + ci;
        end else begin
            full = ua - ub - ci;
            co   = full >= 0;
            sres = sa - sb - ci;
        end
        s  = full & mask;
        ov = (sres > half - 1) || (sres < -half);
        return {29'd0, co, ov, (s == 0), 32'(s)};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        logic rdy_exp;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            rdy_exp = !rst_v && !(o_vld[d] && !out_ready_v);
            chk($sformatf("in_ready w%0d", wid(d)), 64'(o_rdy[d]), 64'(rdy_exp));
            if (stalled[d]) begin
                chk($sformatf("stall valid w%0d", wid(d)), 64'(o_vld[d]), 64'd1);
                chk($sformatf("stall hold w%0d", wid(d)), o_res[d], held_res[d]);
            end
            if (expq[d].size() == 0) begin
                chk($sformatf("idle out_valid w%0d", wid(d)), 64'(o_vld[d]), 64'd0);
            end else if (!rst_v && o_vld[d] && out_ready_v) begin
                e = expq[d].pop_front();
                chk($sformatf("result w%0d", wid(d)), o_res[d], e.res);
                if (lat_chk)
                    chk($sformatf("latency w%0d", wid(d)), 64'(cyc - e.acc), 64'(nb(d) + 1));
            end
            stalled[d]  = !rst_v && o_vld[d] && !out_ready_v;
            held_res[d] = o_res[d];
            if (rst_v) begin
                expq[d].delete();
            end else if (in_valid_v && rdy_exp) begin
                e.res = (d == 0 && dir_en) ? dir_res : model(wid(d), a_v, b_v, cin_v, sub_v);
                e.acc = cyc + 1;
                expq[d].push_back(e);
            end
        end
        @(negedge clk);
    endtask

    function automatic logic pending();
        logic p = 1'b0;
        for (int d = 0; d < NDUT; d++)
            if (expq[d].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(int unsigned budget);
        int unsigned n = 0;
        in_valid_v  = 1'b0;
        out_ready_v = 1'b1;
        while (n < budget && pending()) begin
            tick();
            n++;
        end
        for (int d = 0; d < NDUT; d++)
            chk($sformatf("drained w%0d", wid(d)), 64'(expq[d].size()), 64'd0);
    endtask

    task automatic randomize_beat();
        a_v   = {$urandom, $urandom};
        b_v   = {$urandom, $urandom};
        cin_v = 1'($urandom_range(0, 1));
        sub_v = 1'($urandom_range(0, 1));
    endtask

    task automatic send_dir(logic [15:0] a, logic [15:0] b, logic cin, logic sub,
                            logic [15:0] s, logic co, logic ov, logic z);
        a_v        = 64'(a);
        b_v        = 64'(b);
        cin_v      = cin;
        sub_v      = sub;
        in_valid_v = 1'b1;
        dir_en     = 1'b1;
        dir_res    = {29'd0, co, ov, z, 16'd0, s};
        tick();
        dir_en = 1'b0;
        drain(20);
    endtask

    initial begin
        rst_v       = 1'b1;
        in_valid_v  = 1'b0;
        out_ready_v = 1'b1;
        a_v         = '0;
        b_v         = '0;
        cin_v       = 1'b0;
        sub_v       = 1'b0;
        lat_chk     = 1'b0;
        dir_en      = 1'b0;
        dir_res     = '0;
        for (int d = 0; d < NDUT; d++) begin
            stalled[d]  = 1'b0;
            held_res[d] = '0;
        end
        @(negedge clk);
        in_valid_v = 1'b1;
        tick();
        tick();
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("reset out_valid w%0d", wid(d)), 64'(o_vld[d]), 64'd0);
            chk($sformatf("reset outputs w%0d", wid(d)), o_res[d], 64'd0);
        end
        rst_v      = 1'b0;
        in_valid_v = 1'b0;

        lat_chk = 1'b1;
        send_dir(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
        send_dir(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        send_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        send_dir(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        send_dir(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        send_dir(16'h0010, 16'h000F, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

        lat_chk = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            randomize_beat();
            in_valid_v  = 1'b1;
            out_ready_v = !((c >= 7 && c <= 10) || c == 14);
            tick();
        end
        drain(40);

        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_beat();
            in_valid_v = 1'b1;
            tick();
        end
        randomize_beat();
        rst_v = 1'b1;
        tick();
        rst_v      = 1'b0;
        in_valid_v = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        randomize_beat();
        in_valid_v = 1'b1;
        tick();
        drain(20);

        for (int i = 0; i < 1000; i++) begin
            randomize_beat();
            in_valid_v  = 1'b1;
            out_ready_v = 1'b1;
            tick();
        end
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
